// File: rtl/bp_lite_to_burst_pkg.sv
// Shared BedRock definitions for the Lite-to-Burst converter.
// Header layout (MSB..LSB): {payload, addr, size, msg_type}; the packed
// struct below describes the fixed part, the payload sits above it.
package bp_lite_to_burst_pkg;

  localparam int unsigned bedrock_addr_width_gp     = 40;
  localparam int unsigned bedrock_msg_type_width_gp = 4;
  localparam int unsigned bedrock_msg_size_width_gp = 3;
  localparam int unsigned bedrock_msg_type_count_gp = 1 << bedrock_msg_type_width_gp;

  // Bit positions of the fields the converter decodes
  localparam int unsigned bedrock_msg_type_lsb_gp = 0;
  localparam int unsigned bedrock_msg_size_lsb_gp = bedrock_msg_type_width_gp;

  typedef enum logic [bedrock_msg_type_width_gp-1:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [bedrock_msg_size_width_gp-1:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [bedrock_addr_width_gp-1:0] addr;
    bp_bedrock_msg_size_e             size;
    bp_bedrock_mem_type_e             msg_type;
  } bp_bedrock_hdr_base_s;

  localparam int unsigned bedrock_hdr_base_width_gp = $bits(bp_bedrock_hdr_base_s);

  typedef enum logic {e_ready, e_busy}  bp_piso_state_e;
  typedef enum logic {e_empty, e_full}  bp_hdr_state_e;

  // Number of burst beats for a message: zero without data, otherwise
  // at least one beat and never more than the Lite payload holds.
  function automatic int unsigned burst_beats(input logic                 has_data,
                                              input bp_bedrock_msg_size_e size,
                                              input int unsigned          beat_bytes,
                                              input int unsigned          max_beats);
    int unsigned n;
    if (!has_data) return 0;
    n = (32'd1 << size) / beat_bytes;
    if (n == 0) n = 1;
    if (n > max_beats) n = max_beats;
    return n;
  endfunction

endpackage

// File: rtl/bp_lite_to_burst_piso.sv
// Parallel-in serial-out beat generator for the Lite-to-Burst converter.
// Loads max_els_p words at once and emits words 0..load_len in order.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   load_data/len/v/ready   parallel load (ready-valid-and), len = beats-1
//   beat/beat_v/beat_ready  serial output (ready-valid-and)
module bp_lite_to_burst_piso
  import bp_lite_to_burst_pkg::*;
  #(parameter int unsigned width_p   = 64
  , parameter int unsigned max_els_p = 8
  , localparam int unsigned len_width_lp = (max_els_p > 1) ? $clog2(max_els_p) : 1
  )
  (input  logic                           clk
  , input  logic                          reset
  , input  logic [max_els_p*width_p-1:0]  load_data
  , input  logic [len_width_lp-1:0]       load_len
  , input  logic                          load_v
  , output logic                          load_ready
  , output logic [width_p-1:0]            beat
  , output logic                          beat_v
  , input  logic                          beat_ready
  );

  bp_piso_state_e state, state_n;
  logic [len_width_lp-1:0] cnt, cnt_n, last;
  logic [max_els_p-1:0][width_p-1:0] words;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= e_ready;
      cnt   <= '0;
      last  <= '0;
      words <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load_v && load_ready) begin
        words <= load_data;
        last  <= load_len;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    load_ready = (state == e_ready);
    beat_v     = (state == e_busy);
    unique case (state)
      e_ready: begin
        if (load_v) begin
          state_n = e_busy;
          cnt_n   = '0;
        end
      end
      e_busy: begin
        if (beat_ready) begin
          if (cnt == last) begin
            state_n = e_ready;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = e_ready;
    endcase
  end

  assign beat = words[cnt];

endmodule

// File: rtl/bp_lite_to_burst.sv
// Converts a single-beat BedRock Lite message into BedRock Burst form: the
// header goes out on its own channel, the data is serialized into
// out_data_width_p beats on the data channel. The two output channels are
// independent; a new message is accepted only when both are drained.
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   in_msg_i/_v_i/_ready_and_o          Lite message {header, data}
//   out_msg_header_o/_v_o/_ready_and_i  burst header
//   out_msg_data_o/_v_o/_ready_and_i    burst data beats
module bp_lite_to_burst
  import bp_lite_to_burst_pkg::*;
  #(parameter int unsigned in_data_width_p  = 512
  , parameter int unsigned out_data_width_p = 64
  , parameter int unsigned payload_width_p  = 8
  , parameter logic [bedrock_msg_type_count_gp-1:0] payload_mask_p = '0
  , localparam int unsigned burst_words_lp          = in_data_width_p / out_data_width_p
  , localparam int unsigned out_data_bytes_lp       = out_data_width_p / 8
  , localparam int unsigned out_msg_header_width_lp = payload_width_p + bedrock_hdr_base_width_gp
  , localparam int unsigned in_msg_width_lp         = out_msg_header_width_lp + in_data_width_p
  )
  (input  logic                               clk_i
  , input  logic                              reset_i
  , input  logic [in_msg_width_lp-1:0]        in_msg_i
  , input  logic                              in_msg_v_i
  , output logic                              in_msg_ready_and_o
  , output logic [out_msg_header_width_lp-1:0] out_msg_header_o
  , output logic                              out_msg_header_v_o
  , input  logic                              out_msg_header_ready_and_i
  , output logic [out_data_width_p-1:0]       out_msg_data_o
  , output logic                              out_msg_data_v_o
  , input  logic                              out_msg_data_ready_and_i
  );

  if (in_data_width_p <= out_data_width_p) begin : g_chk_ratio
    $error("in_data_width_p must exceed out_data_width_p");
  end
  if (in_data_width_p % out_data_width_p != 0) begin : g_chk_mult
    $error("in_data_width_p must be a multiple of out_data_width_p");
  end

  localparam int unsigned beat_cnt_width_lp = $clog2(burst_words_lp) + 1;
  localparam int unsigned len_width_lp      = (burst_words_lp > 1) ? $clog2(burst_words_lp) : 1;

  logic [out_msg_header_width_lp-1:0] in_header;
  logic [in_data_width_p-1:0]         in_data;
  bp_bedrock_mem_type_e               in_msg_type;
  bp_bedrock_msg_size_e               in_size;
  logic                               has_data;
  logic [beat_cnt_width_lp-1:0]       beats;
  logic [len_width_lp-1:0]            piso_len;
  logic                               in_fire;
  logic                               piso_load_ready;
  logic                               piso_beat_v;

  assign {in_header, in_data} = in_msg_i;
  assign in_msg_type = bp_bedrock_mem_type_e'(
    in_header[bedrock_msg_type_lsb_gp+:bedrock_msg_type_width_gp]);
  assign in_size     = bp_bedrock_msg_size_e'(
    in_header[bedrock_msg_size_lsb_gp+:bedrock_msg_size_width_gp]);
  assign has_data    = payload_mask_p[in_msg_type];
  assign beats       = beat_cnt_width_lp'(
    burst_beats(has_data, in_size, out_data_bytes_lp, burst_words_lp));
  assign piso_len    = len_width_lp'(beats - 1'b1);

  // Header buffer
  bp_hdr_state_e hdr_state, hdr_state_n;
  logic [out_msg_header_width_lp-1:0] hdr_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hdr_state <= e_empty;
      hdr_r     <= '0;
    end else begin
      hdr_state <= hdr_state_n;
      if (in_fire) hdr_r <= in_header;
    end
  end

  // No bypass: a full buffer blocks input, so empty and refill never coincide
  always_comb begin
    hdr_state_n = hdr_state;
    unique case (hdr_state)
      e_empty: if (in_fire) hdr_state_n = e_full;
      e_full:  if (out_msg_header_ready_and_i) hdr_state_n = e_empty;
      default: hdr_state_n = e_empty;
    endcase
  end

  // Both readiness terms are registered state, so output readies never
  // reach in_msg_ready_and_o combinationally.
  assign in_msg_ready_and_o = ~reset_i & (hdr_state == e_empty) & piso_load_ready;
  assign in_fire            = in_msg_v_i & in_msg_ready_and_o;

  assign out_msg_header_o   = hdr_r;
  assign out_msg_header_v_o = ~reset_i & (hdr_state == e_full);

  bp_lite_to_burst_piso
    #(.width_p(out_data_width_p)
    , .max_els_p(burst_words_lp)
    )
    piso
    (.clk(clk_i)
    , .reset(reset_i)
    , .load_data(in_data)
    , .load_len(piso_len)
    , .load_v(in_fire & (beats != '0))
    , .load_ready(piso_load_ready)
    , .beat(out_msg_data_o)
    , .beat_v(piso_beat_v)
    , .beat_ready(out_msg_data_ready_and_i)
    );

  assign out_msg_data_v_o = ~reset_i & piso_beat_v;

endmodule

// File: tb/tb_bp_lite_to_burst.sv
// Self-checking bench for bp_lite_to_burst (512-bit Lite, 64-bit beats).
module tb_bp_lite_to_burst;
  import bp_lite_to_burst_pkg::*;

  localparam int unsigned in_w  = 512;
  localparam int unsigned out_w = 64;
  localparam int unsigned pay_w = 8;
  localparam logic [15:0] mask  = 16'b0000_0000_0000_1010; // wr, uc_wr carry data
  localparam int unsigned hdr_w = pay_w + $bits(bp_bedrock_hdr_base_s);
  localparam int unsigned msg_w = hdr_w + in_w;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [msg_w-1:0] in_msg = '0;
  logic             in_v = 1'b0;
  logic             in_ready;
  logic [hdr_w-1:0] hdr;
  logic             hdr_v;
  logic             hdr_rdy = 1'b0;
  logic [out_w-1:0] dat;
  logic             dat_v;
  logic             dat_rdy = 1'b0;
  logic             rand_mode = 1'b0;

  int asserts = 0;
  int fails   = 0;

  logic [hdr_w-1:0] hdr_q[$];
  logic [out_w-1:0] data_q[$];

  bp_lite_to_burst
    #(.in_data_width_p(in_w)
    , .out_data_width_p(out_w)
    , .payload_width_p(pay_w)
    , .payload_mask_p(mask)
    )
    dut
    (.clk_i(clk)
    , .reset_i(rst)
    , .in_msg_i(in_msg)
    , .in_msg_v_i(in_v)
    , .in_msg_ready_and_o(in_ready)
    , .out_msg_header_o(hdr)
    , .out_msg_header_v_o(hdr_v)
    , .out_msg_header_ready_and_i(hdr_rdy)
    , .out_msg_data_o(dat)
    , .out_msg_data_v_o(dat_v)
    , .out_msg_data_ready_and_i(dat_rdy)
    );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    asserts++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [hdr_w-1:0] mk_hdr(input bp_bedrock_mem_type_e ty,
                                             input bp_bedrock_msg_size_e sz,
                                             input logic [39:0] addr,
                                             input logic [pay_w-1:0] payload);
    bp_bedrock_hdr_base_s b;
    b.addr = addr;
    b.size = sz;
    b.msg_type = ty;
    return {payload, b};
  endfunction

  // Reference beat count: writes carry data; 8-byte beats, 1..8 of them
  function automatic int unsigned exp_beats(input logic [hdr_w-1:0] h);
    logic [3:0]  ty;
    logic [2:0]  sz;
    int unsigned bytes;
    int unsigned n;
    ty = h[3:0];
    sz = h[6:4];
    if (!(ty == 4'd1 || ty == 4'd3)) return 0;
    bytes = 1 << sz;
    n = bytes / 8;
    if (n < 1) n = 1;
    if (n > 8) n = 8;
    return n;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge
  logic             prev_hv = 1'b0, prev_hfire = 1'b0, prev_dv = 1'b0, prev_dfire = 1'b0;
  logic [hdr_w-1:0] prev_hdr = '0;
  logic [out_w-1:0] prev_dat = '0;
  logic [hdr_w-1:0] mh;
  logic [in_w-1:0]  md;
  int unsigned      nb;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_hdr_v", hdr_v, 0);
      check("rst_data_v", dat_v, 0);
      hdr_q.delete();
      data_q.delete();
      prev_hv = 1'b0;
      prev_dv = 1'b0;
    end else begin
      if (prev_hv && !prev_hfire) begin
        check("hdr_hold_v", hdr_v, 1);
        check("hdr_hold_val", hdr, prev_hdr);
      end
      if (prev_dv && !prev_dfire) begin
        check("data_hold_v", dat_v, 1);
        check("data_hold_val", dat, prev_dat);
      end
      if (in_v && in_ready) begin
        {mh, md} = in_msg;
        nb = exp_beats(mh);
        hdr_q.push_back(mh);
        for (int unsigned k = 0; k < nb; k++) data_q.push_back(md[k*out_w +: out_w]);
      end
      if (hdr_v && hdr_rdy) begin
        check("hdr_expected", hdr_q.size() != 0, 1);
        if (hdr_q.size() != 0) check("hdr_value", hdr, hdr_q.pop_front());
      end
      if (dat_v && dat_rdy) begin
        check("beat_expected", data_q.size() != 0, 1);
        if (data_q.size() != 0) check("beat_value", dat, data_q.pop_front());
      end
      prev_hv    = hdr_v;
      prev_hfire = hdr_v && hdr_rdy;
      prev_hdr   = hdr;
      prev_dv    = dat_v;
      prev_dfire = dat_v && dat_rdy;
      prev_dat   = dat;
    end
  end

  task automatic randomize_readies();
    if (rand_mode) begin
      dat_rdy = 1'($urandom_range(0, 1));
      hdr_rdy = 1'($urandom_range(0, 1));
    end
  endtask

  // Present one message and hold it until accepted; returns 1 ns after the accepting edge
  task automatic send(input logic [hdr_w-1:0] h, input logic [in_w-1:0] d);
    int n;
    @(posedge clk);
    #1;
    in_msg = {h, d};
    in_v = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) break;
      @(posedge clk);
      #1;
      randomize_readies();
    end
    check("send_accepted", in_ready, 1);
    @(posedge clk);
    #1;
    in_v = 1'b0;
    randomize_readies();
  endtask

  // Falling edges observed until in_ready is seen high (inclusive)
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    check("wait_ready_seen", in_ready, 1);
  endtask

  initial begin
    int n;
    logic [in_w-1:0] pat;
    logic [in_w-1:0] rd;
    bp_bedrock_mem_type_e ty;

    for (int i = 0; i < 64; i++) pat[i*8 +: 8] = 8'(i);

    // Reset and idle state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    check("idle_hdr_v", hdr_v, 0);
    check("idle_data_v", dat_v, 0);

    hdr_rdy = 1'b1;
    dat_rdy = 1'b1;

    // 64B write: 8 beats, ready the cycle after beat 7
    send(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h10_0000_1000, 8'h11), pat);
    wait_ready(n);
    check("wr64_ready_latency", n, 9);
    check("wr64_beats_left", data_q.size(), 0);
    check("wr64_hdr_left", hdr_q.size(), 0);

    // 64B read: header only
    send(mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h20_0000_0040, 8'h22), pat);
    wait_ready(n);
    check("rd64_ready_latency", n, 2);
    check("rd64_hdr_left", hdr_q.size(), 0);

    // 8B and 1B writes: one beat each
    send(mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h30_0000_0008, 8'h33), ~pat);
    wait_ready(n);
    check("wr8_ready_latency", n, 2);
    send(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_1, 40'h30_0000_0001, 8'h44), pat);
    wait_ready(n);
    check("wr1_ready_latency", n, 2);
    check("small_beats_left", data_q.size(), 0);

    // Header channel stalled for 20 cycles while data flows
    hdr_rdy = 1'b0;
    send(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h40_0000_0000, 8'h55), ~pat);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("stall_hdr_v", hdr_v, 1);
      check("stall_in_ready", in_ready, 0);
    end
    check("stall_beats_done", data_q.size(), 0);
    check("stall_hdr_pending", hdr_q.size(), 1);
    @(posedge clk);
    #1 hdr_rdy = 1'b1;
    wait_ready(n);
    check("stall_release_latency", n, 2);

    // Reset after beat 3 of 8
    send(mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h50_0000_0000, 8'h66), pat);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_ready", in_ready, 1);
    check("post_reset_hdr_v", hdr_v, 0);
    check("post_reset_data_v", dat_v, 0);
    send(mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_64, 40'h60_0000_0000, 8'h77), ~pat);
    wait_ready(n);
    check("post_reset_wr64_latency", n, 9);
    check("post_reset_beats_left", data_q.size(), 0);

    // Random traffic with random output readiness
    rand_mode = 1'b1;
    for (int m = 0; m < 1000; m++) begin
      for (int w = 0; w < 16; w++) rd[w*32 +: 32] = $urandom();
      case ($urandom_range(0, 4))
        0:       ty = e_bedrock_mem_rd;
        1:       ty = e_bedrock_mem_wr;
        2:       ty = e_bedrock_mem_uc_rd;
        3:       ty = e_bedrock_mem_uc_wr;
        default: ty = e_bedrock_mem_amo;
      endcase
      send(mk_hdr(ty, bp_bedrock_msg_size_e'($urandom_range(0, 7)),
                  {$urandom(), 8'($urandom())}, 8'($urandom())), rd);
    end
    rand_mode = 1'b0;
    hdr_rdy = 1'b1;
    dat_rdy = 1'b1;
    wait_ready(n);
    check("random_hdr_left", hdr_q.size(), 0);
    check("random_beats_left", data_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
